// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns the M-mode trap CSRs, detects exceptions,
// arbitrates interrupts, and runs the trap-entry/ack handshake and mret.
module trap_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_LOCAL = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      pc,
    input  logic                 boundary,
    input  logic                 ld_req,
    input  logic                 st_req,
    input  logic [XLEN-1:0]      mem_addr,
    input  logic [1:0]           mem_size,
    input  logic                 illegal,
    input  logic                 irq_timer,
    input  logic                 irq_ext,
    input  logic [NUM_LOCAL-1:0] irq_local,
    input  logic                 csr_we,
    input  logic [11:0]          csr_addr,
    input  logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_rdata,
    input  logic                 mret,
    input  logic                 trap_ack,
    output logic                 trap,
    output logic [XLEN-1:0]      trap_pc,
    output logic [XLEN-1:0]      mret_pc
);

    localparam int unsigned CW = 5;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    localparam logic [XLEN-1:0] MIE_MASK =
        XLEN'(((64'd1 << NUM_LOCAL) - 64'd1) << 16) | XLEN'(64'h888);

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t state_q, state_n;

    logic                 mstatus_mie_q, mstatus_mpie_q;
    logic [XLEN-1:0]      mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, trap_pc_q;
    logic                 msip_q, timer_q, ext_q;
    logic [NUM_LOCAL-1:0] local_q;

    logic [XLEN-1:0] mip_c, pend_c;
    logic            mis_c, exc_valid_c, irq_valid_c, evt_valid_c, evt_intr_c;
    logic [CW-1:0]   exc_code_c, irq_code_c, evt_code_c;
    logic [XLEN-1:0] exc_tval_c, evt_tval_c, evt_cause_c, evt_pc_c, base_c;
    logic            enter_c, mret_c, csr_c;

    // Pending vector: software bit plus one-cycle-registered hardware levels
    always_comb begin
        mip_c                     = '0;
        mip_c[3]                  = msip_q;
        mip_c[7]                  = timer_q;
        mip_c[11]                 = ext_q;
        mip_c[16 +: NUM_LOCAL]    = local_q;
    end

    // Synchronous exceptions in fixed priority order
    always_comb begin
        case (mem_size)
            2'd0:    mis_c = 1'b0;
            2'd1:    mis_c = mem_addr[0];
            default: mis_c = |mem_addr[1:0];
        endcase
        exc_valid_c = 1'b1;
        exc_code_c  = CW'(0);
        exc_tval_c  = pc;
        if (pc[1:0] != 2'b00) begin
            exc_code_c = CW'(0);
        end else if (illegal) begin
            exc_code_c = CW'(2);
        end else if (ld_req && mis_c) begin
            exc_code_c = CW'(4);
            exc_tval_c = mem_addr;
        end else if (st_req && mis_c) begin
            exc_code_c = CW'(6);
            exc_tval_c = mem_addr;
        end else begin
            exc_valid_c = 1'b0;
        end
    end

    // Interrupt arbitration: MEI > MSI > MTI > locals (lowest index first)
    always_comb begin
        pend_c      = mip_c & mie_q;
        irq_valid_c = mstatus_mie_q && (|pend_c);
        irq_code_c  = CW'(0);
        for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
            if (pend_c[16 + i]) irq_code_c = CW'(16 + i);
        end
        if (pend_c[7])  irq_code_c = CW'(7);
        if (pend_c[3])  irq_code_c = CW'(3);
        if (pend_c[11]) irq_code_c = CW'(11);
    end

    // Taken event and its handler PC
    always_comb begin
        evt_valid_c = boundary && (exc_valid_c || irq_valid_c);
        evt_intr_c  = !exc_valid_c;
        evt_code_c  = exc_valid_c ? exc_code_c : irq_code_c;
        evt_tval_c  = exc_valid_c ? exc_tval_c : '0;
        evt_cause_c = XLEN'(evt_code_c);
        evt_cause_c[XLEN-1] = evt_intr_c;
        base_c      = {mtvec_q[XLEN-1:2], 2'b00};
        evt_pc_c    = (mtvec_q[1:0] == 2'b01 && evt_intr_c)
                    ? base_c + XLEN'({evt_code_c, 2'b00}) : base_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (evt_valid_c) state_n = ST_ACK;
            ST_ACK:  if (trap_ack)    state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Only IDLE accepts trap entry, mret and CSR writes
    always_comb begin
        enter_c = 1'b0;
        mret_c  = 1'b0;
        csr_c   = 1'b0;
        if (state_q == ST_IDLE) begin
            enter_c = evt_valid_c;
            mret_c  = mret && !evt_valid_c;
            csr_c   = csr_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            trap_pc_q      <= '0;
            msip_q         <= 1'b0;
            timer_q        <= 1'b0;
            ext_q          <= 1'b0;
            local_q        <= '0;
        end else begin
            timer_q <= irq_timer;
            ext_q   <= irq_ext;
            local_q <= irq_local;

            if (csr_c && csr_addr == A_MIE)   mie_q   <= csr_wdata & MIE_MASK;
            if (csr_c && csr_addr == A_MTVEC) mtvec_q <= csr_wdata;
            if (csr_c && csr_addr == A_MIP)   msip_q  <= csr_wdata[3];

            // Trap entry overrides any same-cycle write to the trap CSRs
            if (enter_c) begin
                mepc_q         <= {pc[XLEN-1:2], 2'b00};
                mcause_q       <= evt_cause_c;
                mtval_q        <= evt_tval_c;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                trap_pc_q      <= evt_pc_c;
            end else begin
                if (mret_c) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end else if (csr_c && csr_addr == A_MSTATUS) begin
                    mstatus_mie_q  <= csr_wdata[3];
                    mstatus_mpie_q <= csr_wdata[7];
                end
                if (csr_c && csr_addr == A_MEPC)   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
                if (csr_c && csr_addr == A_MCAUSE) mcause_q <= csr_wdata;
                if (csr_c && csr_addr == A_MTVAL)  mtval_q  <= csr_wdata;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS: begin
                csr_rdata[3] = mstatus_mie_q;
                csr_rdata[7] = mstatus_mpie_q;
            end
            A_MIE:    csr_rdata = mie_q;
            A_MTVEC:  csr_rdata = mtvec_q;
            A_MEPC:   csr_rdata = mepc_q;
            A_MCAUSE: csr_rdata = mcause_q;
            A_MTVAL:  csr_rdata = mtval_q;
            A_MIP:    csr_rdata = mip_c;
            default:  csr_rdata = '0;
        endcase
    end

    assign trap    = (state_q == ST_ACK);
    assign trap_pc = trap_pc_q;
    assign mret_pc = mepc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vectors, a behavioural CSR/trap model checked
// every cycle, plus literal expectations on key values.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, mem_addr, csr_wdata, csr_rdata, trap_pc, mret_pc;
    logic        boundary, ld_req, st_req, illegal, irq_timer, irq_ext;
    logic [1:0]  mem_size;
    logic [7:0]  irq_local;
    logic        csr_we, mret, trap_ack, trap;
    logic [11:0] csr_addr;

    int tests = 0;
    int fails = 0;

    trap_ctrl #(.XLEN(32), .NUM_LOCAL(8)) dut (
        .clk(clk), .reset(reset), .pc(pc), .boundary(boundary),
        .ld_req(ld_req), .st_req(st_req), .mem_addr(mem_addr), .mem_size(mem_size),
        .illegal(illegal), .irq_timer(irq_timer), .irq_ext(irq_ext),
        .irq_local(irq_local), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .mret(mret),
        .trap_ack(trap_ack), .trap(trap), .trap_pc(trap_pc), .mret_pc(mret_pc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_busy, m_mie, m_mpie, m_msip, m_timer, m_ext;
    logic [7:0]  m_local;
    logic [31:0] m_mie_r, m_mtvec, m_mepc, m_mcause, m_mtval, m_tpc;

    function automatic logic [31:0] m_mip();
        return {8'h0, m_local, 4'h0, m_ext, 3'b0, m_timer, 3'b0, m_msip, 3'b0};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h304: return m_mie_r;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip();
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_mie <= 0; m_mpie <= 0; m_msip <= 0;
            m_timer <= 0; m_ext <= 0; m_local <= '0;
            m_mie_r <= '0; m_mtvec <= '0; m_mepc <= '0; m_mcause <= '0;
            m_mtval <= '0; m_tpc <= '0;
        end else begin
            bit          found, intr;
            int          code;
            logic [31:0] tval, pend;
            found = 0; intr = 0; code = 0; tval = 0;
            pend  = m_mip() & m_mie_r;
            if (!m_busy && boundary) begin
                found = 1;
                if (pc % 4 != 0)                      begin code = 0; tval = pc; end
                else if (illegal)                     begin code = 2; tval = pc; end
                else if (ld_req && misaligned(mem_addr, mem_size)) begin code = 4; tval = mem_addr; end
                else if (st_req && misaligned(mem_addr, mem_size)) begin code = 6; tval = mem_addr; end
                else begin
                    found = 0;
                    if (m_mie) begin
                        // Ranked list: 11, 3, 7, then locals 16..23
                        for (int k = 0; k < 11 && !found; k++) begin
                            int c;
                            c = (k == 0) ? 11 : (k == 1) ? 3 : (k == 2) ? 7 : 13 + k;
                            if (pend[c]) begin found = 1; intr = 1; code = c; tval = 0; end
                        end
                    end
                end
            end
            if (found) begin
                m_busy   <= 1;
                m_mepc   <= pc & ~32'h3;
                m_mcause <= intr ? (32'h8000_0000 | 32'(code)) : 32'(code);
                m_mtval  <= tval;
                m_mpie   <= m_mie;
                m_mie    <= 0;
                m_tpc    <= (intr && m_mtvec % 4 == 1) ? (m_mtvec & ~32'h3) + 32'(4 * code)
                                                        : (m_mtvec & ~32'h3);
            end
            if (!m_busy && csr_we) begin
                if (csr_addr == 12'h304) m_mie_r <= csr_wdata & 32'h00FF_0888;
                if (csr_addr == 12'h305) m_mtvec <= csr_wdata;
                if (csr_addr == 12'h344) m_msip  <= csr_wdata[3];
                if (!found) begin
                    if (csr_addr == 12'h300 && !mret) begin m_mie <= csr_wdata[3]; m_mpie <= csr_wdata[7]; end
                    if (csr_addr == 12'h341) m_mepc   <= csr_wdata & ~32'h3;
                    if (csr_addr == 12'h342) m_mcause <= csr_wdata;
                    if (csr_addr == 12'h343) m_mtval  <= csr_wdata;
                end
            end
            if (!m_busy && !found && mret) begin m_mie <= m_mpie; m_mpie <= 1; end
            if (m_busy && trap_ack) m_busy <= 0;
            m_timer <= irq_timer; m_ext <= irq_ext; m_local <= irq_local;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("trap", 32'(trap), 32'(m_busy));
        if (m_busy) chk("trap_pc", trap_pc, m_tpc);
        chk("mret_pc", mret_pc, m_mepc);
        chk("csr_rdata", csr_rdata, m_read(csr_addr));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_wdata = d;
        cyc(1);
        csr_we = 0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic ack();
        trap_ack = 1;
        cyc(1);
        trap_ack = 0;
    endtask

    task automatic clr();
        boundary = 0; ld_req = 0; st_req = 0; illegal = 0; mret = 0;
        mem_size = 0; mem_addr = 0;
    endtask

    initial begin
        reset = 1; pc = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
        irq_timer = 0; irq_ext = 0; irq_local = 0; trap_ack = 0;
        clr();
        cyc(2);
        chk("reset_trap", 32'(trap), 32'h0);
        rd("reset_mstatus", 12'h300, 32'h0);
        reset = 0;
        cyc(1);

        // Fetch misaligned, direct mode
        wr(12'h305, 32'h100);
        pc = 32'h202; boundary = 1;
        cyc(1); clr();
        chk("fetch_trap", 32'(trap), 32'h1);
        chk("fetch_tpc", trap_pc, 32'h100);
        rd("fetch_mcause", 12'h342, 32'h0);
        rd("fetch_mepc", 12'h341, 32'h200);
        rd("fetch_mtval", 12'h343, 32'h202);
        cyc(3);
        chk("fetch_hold", 32'(trap), 32'h1);
        ack();
        chk("fetch_acked", 32'(trap), 32'h0);

        // Illegal beats load misaligned
        pc = 32'h400; boundary = 1; illegal = 1; ld_req = 1; mem_size = 2; mem_addr = 32'h1001;
        cyc(1); clr();
        rd("illegal_mcause", 12'h342, 32'h2);
        rd("illegal_mtval", 12'h343, 32'h400);
        ack();
        pc = 32'h404; boundary = 1; ld_req = 1; mem_size = 1; mem_addr = 32'h1001;
        cyc(1); clr();
        rd("ldmis_mcause", 12'h342, 32'h4);
        rd("ldmis_mtval", 12'h343, 32'h1001);
        ack();
        boundary = 1; st_req = 1; mem_size = 2; mem_addr = 32'h1002;
        cyc(1); clr();
        rd("stmis_mcause", 12'h342, 32'h6);
        ack();
        boundary = 1; st_req = 1; mem_size = 0; mem_addr = 32'h1003;
        cyc(1); clr();
        chk("byte_no_trap", 32'(trap), 32'h0);

        // MEI beats MTI, vectored
        irq_timer = 1; irq_ext = 1;
        wr(12'h304, 32'h880);
        wr(12'h305, 32'h101);
        wr(12'h300, 32'h8);
        pc = 32'h500; boundary = 1;
        cyc(1); clr();
        rd("mei_mcause", 12'h342, 32'h8000_000B);
        rd("mei_mstatus", 12'h300, 32'h80);
        chk("mei_tpc", trap_pc, 32'h12C);
        irq_timer = 0; irq_ext = 0;
        ack();
        cyc(1);
        mret = 1; boundary = 1;
        cyc(1); clr();
        rd("mret_mstatus", 12'h300, 32'h88);
        chk("mret_pc", mret_pc, 32'h500);
        pc = 32'h504; boundary = 1; illegal = 1;
        cyc(1); clr();
        mret = 1;
        cyc(1); clr();
        rd("mret_in_ack", 12'h300, 32'h80);
        ack();

        // Local interrupt 17 (lowest index of 17,18)
        irq_local = 8'h06;
        wr(12'h304, 32'h0006_0000);
        wr(12'h305, 32'h201);
        wr(12'h300, 32'h8);
        pc = 32'h600; boundary = 1;
        cyc(1); clr();
        rd("local_mcause", 12'h342, 32'h8000_0011);
        chk("local_tpc", trap_pc, 32'h244);
        irq_local = 0;
        ack();

        // Masked timer, then enable via mstatus
        wr(12'h304, 32'h80);
        irq_timer = 1; pc = 32'h604; boundary = 1;
        cyc(3);
        chk("masked_no_trap", 32'(trap), 32'h0);
        wr(12'h300, 32'h8);
        chk("enable_edge", 32'(trap), 32'h0);
        cyc(1); clr();
        chk("enable_trap", 32'(trap), 32'h1);
        rd("mti_mcause", 12'h342, 32'h8000_0007);
        chk("mti_tpc", trap_pc, 32'h21C);
        irq_timer = 0;
        ack();

        // mip read-only except msip; MSI beats MTI
        cyc(1);
        wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_ro", 12'h344, 32'h8);
        wr(12'h304, 32'h88);
        irq_timer = 1;
        wr(12'h300, 32'h8);
        pc = 32'h700; boundary = 1;
        cyc(1); clr();
        rd("msi_mcause", 12'h342, 32'h8000_0003);
        irq_timer = 0;
        ack();
        wr(12'h344, 32'h0);

        // Trap entry beats same-cycle mepc write
        pc = 32'h710; boundary = 1; illegal = 1;
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h1234;
        cyc(1); clr(); csr_we = 0;
        rd("entry_wins", 12'h341, 32'h710);
        ack();
        wr(12'h341, 32'h1237);
        rd("mepc_align", 12'h341, 32'h1234);
        rd("unowned", 12'h340, 32'h0);
        wr(12'h300, 32'hFFFF_FFFF);
        rd("mstatus_bits", 12'h300, 32'h88);
        wr(12'h300, 32'h0);

        // Async reset while waiting for ack
        pc = 32'h720; boundary = 1; illegal = 1;
        cyc(1); clr();
        chk("pre_reset_trap", 32'(trap), 32'h1);
        reset = 1;
        #2;
        chk("async_reset_trap", 32'(trap), 32'h0);
        rd("async_reset_mtvec", 12'h305, 32'h0);
        cyc(1);
        reset = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
